fifo_sc: RTL and testbench



---
 rtl/fifo_pkg.sv | 18 +
 rtl/ram_sc_sdp.sv | 50 +++++
 rtl/fifo_sc.sv | 135 +++++++++++++
 tb/tb_fifo_sc.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and types for the fifo library.
package fifo_pkg;

    localparam int DEF_W_DATA  = 8;
    localparam int DEF_W_DEPTH = 16;
    localparam int DEF_W_ADDR  = $clog2(DEF_W_DEPTH);

    // Types sized for the default configuration.
    typedef logic [DEF_W_DATA-1:0] data_t;
    typedef logic [DEF_W_ADDR:0]   ptr_t;
    typedef logic [DEF_W_ADDR:0]   count_t;

    // True when n is a power of two and at least 2.
    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/ram_sc_sdp.sv
// Single-clock simple dual-port RAM with a registered read port.
// Storage is not reset; the read register is, so the read data is defined from reset.
module ram_sc_sdp
    import fifo_pkg::*;
#(
    parameter int W_DATA  = DEF_W_DATA,
    parameter int W_DEPTH = DEF_W_DEPTH,
    localparam int W_ADDR = $clog2(W_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_wr,
    input  logic [W_ADDR-1:0] addr_wr,
    input  logic [W_DATA-1:0] data_wr,
    input  logic              en_rd,
    input  logic [W_ADDR-1:0] addr_rd,
    output logic [W_DATA-1:0] data_rd
);

    logic [W_DATA-1:0] mem_q [W_DEPTH];
    logic [W_DATA-1:0] data_rd_d;
    logic [W_DATA-1:0] data_rd_q;

    // Write port: store the word on an enabled write.
    always_ff @(posedge clk) begin
        if (en_wr) begin
            mem_q[addr_wr] <= data_wr;
        end
    end

    // Read data: load on an enabled read, otherwise hold.
    always_comb begin
        data_rd_d = data_rd_q;
        if (en_rd) begin
            data_rd_d = mem_q[addr_rd];
        end
    end

    // Read register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_rd_q <= '0;
        end else begin
            data_rd_q <= data_rd_d;
        end
    end

    assign data_rd = data_rd_q;

endmodule

// File: rtl/fifo_sc.sv
// Single-clock synchronous FIFO with occupancy count, threshold flags and
// sticky overflow/underflow flags, built on ram_sc_sdp.
module fifo_sc
    import fifo_pkg::*;
#(
    parameter int W_DATA   = DEF_W_DATA,
    parameter int W_DEPTH  = DEF_W_DEPTH,
    localparam int W_ADDR  = $clog2(W_DEPTH),
    parameter int AF_LEVEL = W_DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [W_DATA-1:0] data_in,
    input  logic              pop,
    input  logic              clr_err,
    output logic [W_DATA-1:0] data_out,
    output logic              data_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [W_ADDR:0]   count,
    output logic              overflow,
    output logic              underflow
);

    typedef logic [W_ADDR:0] fptr_t;

    localparam fptr_t DEPTH_C = fptr_t'(W_DEPTH);
    localparam fptr_t AF_C    = fptr_t'(AF_LEVEL);
    localparam fptr_t AE_C    = fptr_t'(AE_LEVEL);

    if (!is_pow2(W_DEPTH)) begin : g_bad_depth
        $error("fifo_sc: W_DEPTH must be a power of two >= 2");
    end
    if (!(AE_LEVEL >= 0 && AE_LEVEL < AF_LEVEL && AF_LEVEL <= W_DEPTH)) begin : g_bad_thr
        $error("fifo_sc: thresholds must satisfy 0 <= AE_LEVEL < AF_LEVEL <= W_DEPTH");
    end

    fptr_t wr_ptr_q, wr_ptr_d;
    fptr_t rd_ptr_q, rd_ptr_d;
    fptr_t count_q, count_d;
    logic  full_q, full_d;
    logic  empty_q, empty_d;
    logic  af_q, af_d;
    logic  ae_q, ae_d;
    logic  overflow_q, overflow_d;
    logic  underflow_q, underflow_d;
    logic  data_valid_q, data_valid_d;
    logic  push_ok, pop_ok;

    // Acceptance, pointer/count update, flags from next count, sticky errors.
    always_comb begin
        push_ok = push && !full_q;
        pop_ok  = pop && !empty_q;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + fptr_t'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + fptr_t'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + fptr_t'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - fptr_t'(1);
        end

        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
        af_d    = (count_d >= AF_C);
        ae_d    = (count_d <= AE_C);

        // A new error in the same cycle as clr_err keeps the flag set.
        overflow_d   = (push && full_q) || (overflow_q && !clr_err);
        underflow_d  = (pop && empty_q) || (underflow_q && !clr_err);
        data_valid_d = pop_ok;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            af_q         <= 1'b0;
            ae_q         <= 1'b1;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            data_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            af_q         <= af_d;
            ae_q         <= ae_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            data_valid_q <= data_valid_d;
        end
    end

    ram_sc_sdp #(
        .W_DATA  (W_DATA),
        .W_DEPTH (W_DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_wr   (push_ok),
        .addr_wr (wr_ptr_q[W_ADDR-1:0]),
        .data_wr (data_in),
        .en_rd   (pop_ok),
        .addr_rd (rd_ptr_q[W_ADDR-1:0]),
        .data_rd (data_out)
    );

    assign data_valid   = data_valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sc.sv
// Directed table-driven bench for fifo_sc (W_DEPTH=4, AF_LEVEL=3, AE_LEVEL=1).
module tb_fifo_sc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       push, pop, clr_err;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_valid, full, empty, almost_full, almost_empty;
    logic [2:0] count;
    logic       overflow, underflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fifo_sc #(
        .W_DATA   (8),
        .W_DEPTH  (4),
        .AF_LEVEL (3),
        .AE_LEVEL (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .clr_err      (clr_err),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    typedef struct {
        bit       p;
        bit [7:0] d;
        bit       po;
        bit       c;
        bit [7:0] e_dout;
        bit       e_dv;
        bit       e_full;
        bit       e_empty;
        bit       e_af;
        bit       e_ae;
        bit [2:0] e_cnt;
        bit       e_ov;
        bit       e_un;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(bit p, bit [7:0] d, bit po, bit c, bit [7:0] eo, bit edv,
                                bit ef, bit ee, bit eaf, bit eae, bit [2:0] ec, bit eov, bit eun);
        vec_t v;
        v.p = p; v.d = d; v.po = po; v.c = c;
        v.e_dout = eo; v.e_dv = edv; v.e_full = ef; v.e_empty = ee;
        v.e_af = eaf; v.e_ae = eae; v.e_cnt = ec; v.e_ov = eov; v.e_un = eun;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, " data_out"},     32'(data_out),     32'(v.e_dout));
        chk({tag, " data_valid"},   32'(data_valid),   32'(v.e_dv));
        chk({tag, " full"},         32'(full),         32'(v.e_full));
        chk({tag, " empty"},        32'(empty),        32'(v.e_empty));
        chk({tag, " almost_full"},  32'(almost_full),  32'(v.e_af));
        chk({tag, " almost_empty"}, 32'(almost_empty), 32'(v.e_ae));
        chk({tag, " count"},        32'(count),        32'(v.e_cnt));
        chk({tag, " overflow"},     32'(overflow),     32'(v.e_ov));
        chk({tag, " underflow"},    32'(underflow),    32'(v.e_un));
    endtask

    task automatic drive(input bit p, input bit [7:0] d, input bit po, input bit c);
        push = p; data_in = d; pop = po; clr_err = c;
    endtask

    initial begin
        vec_t rst_v;
        rst_v = mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 0);

        //            p  d      po c  dout   dv f  e  af ae cnt ov un
        vq.push_back(mk(1, 8'h11, 0, 0, 8'h00, 0, 0, 0, 0, 1, 1, 0, 0));
        vq.push_back(mk(1, 8'h22, 0, 0, 8'h00, 0, 0, 0, 0, 0, 2, 0, 0));
        vq.push_back(mk(1, 8'h33, 0, 0, 8'h00, 0, 0, 0, 1, 0, 3, 0, 0));
        vq.push_back(mk(1, 8'h44, 0, 0, 8'h00, 0, 1, 0, 1, 0, 4, 0, 0));
        vq.push_back(mk(0, 8'h00, 1, 0, 8'h11, 1, 0, 0, 1, 0, 3, 0, 0));
        vq.push_back(mk(0, 8'h00, 1, 0, 8'h22, 1, 0, 0, 0, 0, 2, 0, 0));
        vq.push_back(mk(0, 8'h00, 1, 0, 8'h33, 1, 0, 0, 0, 1, 1, 0, 0));
        vq.push_back(mk(0, 8'h00, 1, 0, 8'h44, 1, 0, 1, 0, 1, 0, 0, 0));
        vq.push_back(mk(0, 8'h00, 0, 0, 8'h44, 0, 0, 1, 0, 1, 0, 0, 0));
        vq.push_back(mk(1, 8'h11, 0, 0, 8'h44, 0, 0, 0, 0, 1, 1, 0, 0));
        vq.push_back(mk(1, 8'h22, 0, 0, 8'h44, 0, 0, 0, 0, 0, 2, 0, 0));
        vq.push_back(mk(1, 8'h33, 0, 0, 8'h44, 0, 0, 0, 1, 0, 3, 0, 0));
        vq.push_back(mk(1, 8'h44, 0, 0, 8'h44, 0, 1, 0, 1, 0, 4, 0, 0));
        vq.push_back(mk(1, 8'h55, 1, 0, 8'h11, 1, 0, 0, 1, 0, 3, 1, 0));
        vq.push_back(mk(0, 8'h00, 0, 1, 8'h11, 0, 0, 0, 1, 0, 3, 0, 0));
        vq.push_back(mk(0, 8'h00, 1, 0, 8'h22, 1, 0, 0, 0, 0, 2, 0, 0));
        vq.push_back(mk(0, 8'h00, 1, 0, 8'h33, 1, 0, 0, 0, 1, 1, 0, 0));
        vq.push_back(mk(0, 8'h00, 1, 0, 8'h44, 1, 0, 1, 0, 1, 0, 0, 0));
        vq.push_back(mk(0, 8'h00, 1, 0, 8'h44, 0, 0, 1, 0, 1, 0, 0, 1));
        vq.push_back(mk(0, 8'h00, 0, 1, 8'h44, 0, 0, 1, 0, 1, 0, 0, 0));
        vq.push_back(mk(1, 8'hA5, 1, 0, 8'h44, 0, 0, 0, 0, 1, 1, 0, 1));
        vq.push_back(mk(0, 8'h00, 1, 0, 8'hA5, 1, 0, 1, 0, 1, 0, 0, 1));
        vq.push_back(mk(0, 8'h00, 1, 1, 8'hA5, 0, 0, 1, 0, 1, 0, 0, 1));
        vq.push_back(mk(0, 8'h00, 0, 1, 8'hA5, 0, 0, 1, 0, 1, 0, 0, 0));

        rst_n = 1'b0;
        drive(0, 8'h00, 0, 0);
        #12;
        chk_all("reset", rst_v);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].p, vq[i].d, vq[i].po, vq[i].c);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vq[i]);
        end

        // Steady stream at count 2; pointers wrap several times.
        drive(1, 8'h60, 0, 0);
        @(posedge clk);
        #1;
        drive(1, 8'h61, 0, 0);
        @(posedge clk);
        #1;
        chk("stream prefill count", 32'(count), 32'd2);
        for (int i = 0; i < 20; i++) begin
            drive(1, 8'(8'h62 + i), 1, 0);
            @(posedge clk);
            #1;
            chk($sformatf("stream%0d data_out", i), 32'(data_out), 32'(8'h60 + i));
            chk($sformatf("stream%0d data_valid", i), 32'(data_valid), 32'd1);
            chk($sformatf("stream%0d count", i), 32'(count), 32'd2);
        end

        // Asynchronous reset in the middle of the stream.
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("midreset", rst_v);
        drive(0, 8'h00, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 8'h7E, 0, 0);
        @(posedge clk);
        #1;
        chk("post-reset push count", 32'(count), 32'd1);
        chk("post-reset push empty", 32'(empty), 32'd0);
        drive(0, 8'h00, 1, 0);
        @(posedge clk);
        #1;
        chk("post-reset pop data_out", 32'(data_out), 32'h7E);
        chk("post-reset pop data_valid", 32'(data_valid), 32'd1);
        chk("post-reset pop empty", 32'(empty), 32'd1);
        drive(0, 8'h00, 0, 0);
        @(posedge clk);
        #1;
        chk("post-reset dv pulse", 32'(data_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
